register_file_sb: RTL and testbench
===================================

// Module: register_file_sb
// PURPOSE
// - Architectural register file plus issue scoreboard; the responder on the ID stage's read ports.
// - Serves two asynchronous reads and one writeback write.
// - Tracks per-register pending-write state, so ID sees value and busy status in one 24-bit word.
// - Sits between the ID stage (reads, reservations) and the WB stage (writes).
// PARAMETERS
// - NREGS    32  number of architectural registers; index width = 5
// - DATA_W   16  register value width
// - TAG_W    4   producer tag width carried with each reservation
// PORTS
// clk                  in   1   rising-edge clock
// rst_n                in   1   asynchronous active-low reset
// read_index_1         in   5   read port 1 register index
// read_index_2         in   5   read port 2 register index
// read_data_1          out  24  {tag[23:20], 3'b0, busy[16], value[15:0]} for index 1
// read_data_2          out  24  same format for index 2
// rsv_valid            in   1   ID issues an instruction writing rsv_index
// rsv_index            in   5   destination register being reserved
// rsv_tag              in   4   producer tag of the issuing instruction
// wb_valid             in   1   WB writes a result
// wb_index             in   5   WB destination register
// wb_data              in   16  WB result value
// wb_tag               in   4   producer tag of the writing instruction
// pending_count        out  6   number of registers with busy=1 (registered)
// BEHAVIOUR
// - Reset: async on rst_n low. All values = 0, busy = 0, tags = 0, pending_count = 0.
//   - Reads during reset return 24'h0.
// - Reads: combinational, zero-latency. Bits [19:17] always 0.
// - R0: always reads 24'h0. Reservations and writebacks to index 0 are ignored entirely.
// - Writeback (posedge, wb_valid, wb_index != 0):
//   - value[wb_index] <= wb_data, unconditionally.
//   - busy is cleared only if busy=1 and tag[wb_index] == wb_tag.
//   - A stale-tag write updates the value but leaves busy/tag intact (WAW safety).
// - Reservation (posedge, rsv_valid, rsv_index != 0): busy <= 1, tag <= rsv_tag. Value is untouched.
//   - Re-reserving an already busy register overwrites the tag. Count is unchanged.
// - Same-cycle reservation and writeback to the same index:
//   - Value takes wb_data.
//   - Busy = 1 and tag = rsv_tag (the reservation wins).
//   - pending_count reflects the net effect.
// - Write-through bypass: when wb_valid and wb_index == read_index_n (nonzero), read_data_n
//   returns the post-writeback view in the same cycle:
//   - value = wb_data;
//   - busy/tag as they will be after the clock edge, excluding any same-cycle reservation.
// - Same-cycle reservations are not bypassed: a read in the reservation cycle shows the old busy/tag.
// - pending_count: registered population count of busy bits. Changes by -1, 0 or +1 per cycle.
//   - Never exceeds 31.
// - Both read ports may address the same register; they return identical words.
// STRUCTURE
// - Shared package pipe_pkg:
//   - REG_IDX_W=5, DATA_W=16, TAG_W=4;
//   - RD_WORD_W=24 and field offsets (VAL_LSB=0, BUSY_BIT=16, TAG_LSB=20);
//   - function pack_rd_word(tag, busy, value).
// - One sub-module: reg_scoreboard. Holds busy[31:1] and tag[31:1], set/clear logic and
//   pending_count. Outputs post-writeback busy/tag views for the bypass muxes.
// - Top level holds the value array, write-through muxes and word packing.
// TESTING
// 1. Reset:
//    - Assert rst_n=0 mid-run after writes -> all reads 24'h0 and pending_count=0 asynchronously.
//    - Still all zero on the first edge after release.
// 2. Write/read:
//    - wb r5=16'hBEEF, tag 0, not busy -> next cycle read_index_1=5 gives 24'h00BEEF.
//    - wb r0=16'h1234 -> read r0 gives 24'h000000.
// 3. Reservation:
//    - rsv r7 tag 4'hA -> read r7 gives 24'hA1xxxx; pending_count=1.
//    - wb r7 tag A data 16'h0042 -> read gives 24'hA00042; count=0.
// 4. Stale tag:
//    - rsv r3 tag 2, then rsv r3 tag 9.
//    - wb r3 tag 2 data 16'h0011 -> read 24'h910011, count=1.
//    - wb r3 tag 9 -> busy clears, count=0.
// 5. Bypass:
//    - r4 busy tag 6; same cycle wb r4 tag 6 data 16'hCAFE with read_index_2=4
//      -> read_data_2 = 24'h60CAFE combinationally.
// 6. Collision:
//    - Same cycle wb r9 tag 1 data 16'h0077 and rsv r9 tag 3, r9 previously busy tag 1
//      -> next cycle read 24'h310077; count unchanged.

Source files
------------

// File: rtl/register_file_sb_pkg.sv
// ============================================================================
// Module  : pipe_pkg
// Brief   : Shared widths, read-word field offsets and word packing helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 16;
  localparam int TAG_W     = 4;
  localparam int RD_WORD_W = 24;
  localparam int VAL_LSB   = 0;
  localparam int BUSY_BIT  = 16;
  localparam int TAG_LSB   = 20;

  function automatic logic [RD_WORD_W-1:0] pack_rd_word(
    input logic [TAG_W-1:0]  tag,
    input logic              busy,
    input logic [DATA_W-1:0] value
  );
    logic [RD_WORD_W-1:0] w;
    w                       = '0;
    w[TAG_LSB +: TAG_W]     = tag;
    w[BUSY_BIT]             = busy;
    w[VAL_LSB +: DATA_W]    = value;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_file_sb_if.sv
// ============================================================================
// Module  : register_file_sb_if
// Brief   : ID/WB-facing bus of the register file: reads, reservations, writebacks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface register_file_sb_if;
  import pipe_pkg::*;

  logic [REG_IDX_W-1:0] read_index_1;
  logic [REG_IDX_W-1:0] read_index_2;
  logic [RD_WORD_W-1:0] read_data_1;
  logic [RD_WORD_W-1:0] read_data_2;
  logic                 rsv_valid;
  logic [REG_IDX_W-1:0] rsv_index;
  logic [TAG_W-1:0]     rsv_tag;
  logic                 wb_valid;
  logic [REG_IDX_W-1:0] wb_index;
  logic [DATA_W-1:0]    wb_data;
  logic [TAG_W-1:0]     wb_tag;
  logic [5:0]           pending_count;

  modport master (
    output read_index_1, read_index_2,
    output rsv_valid, rsv_index, rsv_tag,
    output wb_valid, wb_index, wb_data, wb_tag,
    input  read_data_1, read_data_2, pending_count
  );

  modport slave (
    input  read_index_1, read_index_2,
    input  rsv_valid, rsv_index, rsv_tag,
    input  wb_valid, wb_index, wb_data, wb_tag,
    output read_data_1, read_data_2, pending_count
  );

endinterface

`default_nettype wire

// File: rtl/register_file_sb_reg_scoreboard.sv
// ============================================================================
// Module  : reg_scoreboard
// Brief   : Per-register busy/tag tracking and registered pending count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
  import pipe_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 rsv_valid,
  input  wire logic [REG_IDX_W-1:0] rsv_index,
  input  wire logic [TAG_W-1:0]     rsv_tag,
  input  wire logic                 wb_valid,
  input  wire logic [REG_IDX_W-1:0] wb_index,
  input  wire logic [TAG_W-1:0]     wb_tag,
  input  wire logic [REG_IDX_W-1:0] rd_index_1,
  input  wire logic [REG_IDX_W-1:0] rd_index_2,
  output logic                      rd_busy_1,
  output logic [TAG_W-1:0]          rd_tag_1,
  output logic                      rd_busy_2,
  output logic [TAG_W-1:0]          rd_tag_2,
  output logic                      wb_post_busy,
  output logic [5:0]                pending_count
);

  // Entry 0 is never written, so it always reads as idle with tag 0.
  logic [NREGS-1:0] r_busy;
  logic [TAG_W-1:0] r_tag [NREGS];
  logic [5:0]       r_count;

  logic w_rsv_hit;
  logic w_wb_hit;
  logic w_wb_match;
  logic w_same_idx;
  logic w_inc;
  logic w_dec;

  assign w_rsv_hit  = rsv_valid && (rsv_index != '0);
  assign w_wb_hit   = wb_valid && (wb_index != '0);
  assign w_wb_match = w_wb_hit && r_busy[wb_index] && (r_tag[wb_index] == wb_tag);
  assign w_same_idx = w_rsv_hit && w_wb_hit && (rsv_index == wb_index);
  assign w_inc      = w_rsv_hit && !r_busy[rsv_index];
  assign w_dec      = w_wb_match && !w_same_idx;

  // Tag is not changed by a writeback, so only busy needs a post-write view.
  assign wb_post_busy  = r_busy[wb_index] && (r_tag[wb_index] != wb_tag);
  assign rd_busy_1     = r_busy[rd_index_1];
  assign rd_tag_1      = r_tag[rd_index_1];
  assign rd_busy_2     = r_busy[rd_index_2];
  assign rd_tag_2      = r_tag[rd_index_2];
  assign pending_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= '0;
      r_count <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      if (w_wb_match) begin
        r_busy[wb_index] <= 1'b0;
      end
      // Reservation comes last so it wins a same-index collision.
      if (w_rsv_hit) begin
        r_busy[rsv_index] <= 1'b1;
        r_tag[rsv_index]  <= rsv_tag;
      end
      r_count <= r_count + 6'(w_inc) - 6'(w_dec);
    end
  end

endmodule

`default_nettype wire

// File: rtl/register_file_sb.sv
// ============================================================================
// Module  : register_file_sb
// Brief   : Register file with issue scoreboard and write-through read bypass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_sb
  import pipe_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst_n,
  register_file_sb_if.slave bus
);

  logic [DATA_W-1:0] r_value [NREGS];

  logic              w_wb_hit;
  logic              w_byp_1;
  logic              w_byp_2;
  logic              w_sb_busy_1;
  logic              w_sb_busy_2;
  logic              w_wb_post_busy;
  logic [TAG_W-1:0]  w_tag_1;
  logic [TAG_W-1:0]  w_tag_2;
  logic [DATA_W-1:0] w_val_1;
  logic [DATA_W-1:0] w_val_2;
  logic              w_busy_1;
  logic              w_busy_2;

  assign w_wb_hit = bus.wb_valid && (bus.wb_index != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_value[i] <= '0;
      end
    end else if (w_wb_hit) begin
      r_value[bus.wb_index] <= bus.wb_data;
    end
  end

  reg_scoreboard u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .rsv_valid     (bus.rsv_valid),
    .rsv_index     (bus.rsv_index),
    .rsv_tag       (bus.rsv_tag),
    .wb_valid      (bus.wb_valid),
    .wb_index      (bus.wb_index),
    .wb_tag        (bus.wb_tag),
    .rd_index_1    (bus.read_index_1),
    .rd_index_2    (bus.read_index_2),
    .rd_busy_1     (w_sb_busy_1),
    .rd_tag_1      (w_tag_1),
    .rd_busy_2     (w_sb_busy_2),
    .rd_tag_2      (w_tag_2),
    .wb_post_busy  (w_wb_post_busy),
    .pending_count (bus.pending_count)
  );

  // Write-through: a read of the register being written sees the post-edge value/busy.
  assign w_byp_1  = w_wb_hit && (bus.wb_index == bus.read_index_1);
  assign w_byp_2  = w_wb_hit && (bus.wb_index == bus.read_index_2);
  assign w_val_1  = w_byp_1 ? bus.wb_data    : r_value[bus.read_index_1];
  assign w_val_2  = w_byp_2 ? bus.wb_data    : r_value[bus.read_index_2];
  assign w_busy_1 = w_byp_1 ? w_wb_post_busy : w_sb_busy_1;
  assign w_busy_2 = w_byp_2 ? w_wb_post_busy : w_sb_busy_2;

  assign bus.read_data_1 = (!rst_n || bus.read_index_1 == '0) ? '0
                         : pack_rd_word(w_tag_1, w_busy_1, w_val_1);
  assign bus.read_data_2 = (!rst_n || bus.read_index_2 == '0) ? '0
                         : pack_rd_word(w_tag_2, w_busy_2, w_val_2);

endmodule

`default_nettype wire

// File: tb/tb_register_file_sb.sv
// ============================================================================
// Module  : tb_register_file_sb
// Brief   : Directed and model-checked bench for register_file_sb.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_sb;
  import pipe_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  register_file_sb_if bus ();

  register_file_sb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Architectural model of the register file state
  logic [15:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_read(input logic [4:0] idx);
    logic [15:0] v;
    logic        b;
    logic [3:0]  t;
    if (!rst_n || idx == 5'd0) return 24'h0;
    v = m_val[idx];
    b = m_busy[idx];
    t = m_tag[idx];
    if (bus.wb_valid && bus.wb_index == idx) begin
      v = bus.wb_data;
      if (b && t == bus.wb_tag) b = 1'b0;
    end
    return {t, 3'b000, b, v};
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 1; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_val[i]  = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  task automatic model_update();
    if (!rst_n) return;
    if (bus.wb_valid && bus.wb_index != 5'd0) begin
      m_val[bus.wb_index] = bus.wb_data;
      if (m_busy[bus.wb_index] && m_tag[bus.wb_index] == bus.wb_tag)
        m_busy[bus.wb_index] = 1'b0;
    end
    if (bus.rsv_valid && bus.rsv_index != 5'd0) begin
      m_busy[bus.rsv_index] = 1'b1;
      m_tag[bus.rsv_index]  = bus.rsv_tag;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.rsv_valid = 1'b0;
    bus.rsv_index = '0;
    bus.rsv_tag   = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_index  = '0;
    bus.wb_data   = '0;
    bus.wb_tag    = '0;
  endtask

  task automatic do_rsv(input logic [4:0] idx, input logic [3:0] tag);
    bus.rsv_valid = 1'b1;
    bus.rsv_index = idx;
    bus.rsv_tag   = tag;
  endtask

  task automatic do_wb(input logic [4:0] idx, input logic [3:0] tag, input logic [15:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_index = idx;
    bus.wb_tag   = tag;
    bus.wb_data  = data;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rd1", bus.read_data_1, exp_read(bus.read_index_1));
      chk("model_rd2", bus.read_data_2, exp_read(bus.read_index_2));
      chk("model_cnt", {18'b0, bus.pending_count}, 24'(model_count()));
    end
  end

  initial begin
    idle();
    bus.read_index_1 = '0;
    bus.read_index_2 = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.read_index_1 = 5'd5;
    #1;
    chk("reset_rd", bus.read_data_1, 24'h0);
    chk("reset_cnt", {18'b0, bus.pending_count}, 24'd0);
    chk_en = 1'b1;

    // Plain write and R0 immunity
    do_wb(5'd5, 4'h0, 16'hBEEF);
    tick(); idle();
    #1 chk("wb_r5", bus.read_data_1, 24'h00BEEF);
    do_wb(5'd0, 4'h0, 16'h1234);
    bus.read_index_2 = 5'd0;
    #1 chk("wb_r0_byp", bus.read_data_2, 24'h0);
    tick(); idle();
    #1 chk("rd_r0", bus.read_data_2, 24'h0);

    // Reservation then matching writeback
    do_rsv(5'd7, 4'hA);
    tick(); idle();
    bus.read_index_1 = 5'd7;
    #1 chk("rsv_r7", bus.read_data_1, 24'hA10000);
    chk("rsv_cnt", {18'b0, bus.pending_count}, 24'd1);
    do_wb(5'd7, 4'hA, 16'h0042);
    #1 chk("wb_r7_byp", bus.read_data_1, 24'hA00042);
    tick(); idle();
    #1 chk("wb_r7", bus.read_data_1, 24'hA00042);
    chk("wb_r7_cnt", {18'b0, bus.pending_count}, 24'd0);

    // Stale tag write keeps the newer reservation
    do_rsv(5'd3, 4'h2);
    tick(); idle();
    do_rsv(5'd3, 4'h9);
    tick(); idle();
    #1 chk("rersv_cnt", {18'b0, bus.pending_count}, 24'd1);
    do_wb(5'd3, 4'h2, 16'h0011);
    bus.read_index_2 = 5'd3;
    tick(); idle();
    #1 chk("stale_r3", bus.read_data_2, 24'h910011);
    chk("stale_cnt", {18'b0, bus.pending_count}, 24'd1);
    do_wb(5'd3, 4'h9, 16'h0022);
    tick(); idle();
    #1 chk("match_r3", bus.read_data_2, 24'h900022);
    chk("match_cnt", {18'b0, bus.pending_count}, 24'd0);

    // Combinational bypass on both ports
    do_rsv(5'd4, 4'h6);
    tick(); idle();
    do_wb(5'd4, 4'h6, 16'hCAFE);
    bus.read_index_1 = 5'd4;
    bus.read_index_2 = 5'd4;
    #1 chk("byp_rd2", bus.read_data_2, 24'h60CAFE);
    chk("byp_rd1", bus.read_data_1, 24'h60CAFE);
    tick(); idle();
    #1 chk("byp_cnt", {18'b0, bus.pending_count}, 24'd0);

    // Same-cycle reservation and writeback collision
    do_rsv(5'd9, 4'h1);
    tick(); idle();
    #1 chk("coll_pre_cnt", {18'b0, bus.pending_count}, 24'd1);
    do_wb(5'd9, 4'h1, 16'h0077);
    do_rsv(5'd9, 4'h3);
    bus.read_index_1 = 5'd9;
    #1 chk("coll_byp", bus.read_data_1, 24'h100077);
    tick(); idle();
    #1 chk("coll_r9", bus.read_data_1, 24'h310077);
    chk("coll_cnt", {18'b0, bus.pending_count}, 24'd1);

    // Fill every register: count tops out at 31
    for (int i = 1; i < 32; i++) begin
      do_rsv(5'(i), 4'(i));
      tick();
    end
    idle();
    #1 chk("full_cnt", {18'b0, bus.pending_count}, 24'd31);
    do_rsv(5'd31, 4'h5);
    tick();
    do_rsv(5'd0, 4'h5);
    bus.read_index_1 = 5'd0;
    tick(); idle();
    #1 chk("full_cnt2", {18'b0, bus.pending_count}, 24'd31);
    chk("rsv_r0", bus.read_data_1, 24'h0);

    // Randomised traffic checked by the model every cycle
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1) do_rsv(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 1) == 1 && bus.rsv_valid)
          do_wb(bus.rsv_index, 4'($urandom_range(0, 15)), 16'($urandom));
        else
          do_wb(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 16'($urandom));
      end
      bus.read_index_1 = ($urandom_range(0, 1) == 1) ? bus.wb_index : 5'($urandom_range(0, 31));
      bus.read_index_2 = 5'($urandom_range(0, 31));
      tick();
    end
    idle();

    // Asynchronous reset mid-run
    do_rsv(5'd12, 4'h4);
    tick(); idle();
    do_wb(5'd20, 4'h1, 16'h5555);
    tick(); idle();
    bus.read_index_1 = 5'd20;
    bus.read_index_2 = 5'd12;
    #1 rst_n = 1'b0;
    model_clear();
    #1;
    chk("async_rst_rd1", bus.read_data_1, 24'h0);
    chk("async_rst_rd2", bus.read_data_2, 24'h0);
    chk("async_rst_cnt", {18'b0, bus.pending_count}, 24'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_rd1", bus.read_data_1, 24'h0);
    chk("post_rst_rd2", bus.read_data_2, 24'h0);
    chk("post_rst_cnt", {18'b0, bus.pending_count}, 24'd0);

    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
